// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-port memory between the fetch port and the
// load/store port. Each access is a fixed-latency handshake: a one-cycle
// mem_en strobe, then MEM_LAT cycles until the owner's ready pulse.
// Data normally wins, but a pending fetch is forced through after
// STARVE_MAX consecutive data grants.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,   // 1..7
  parameter int STARVE_MAX = 3    // 1..15
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // load/store port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_byte,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  // memory macro
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // pipeline stalls
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int LAT_W = 3;
  localparam int STV_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q;
  logic [STV_W-1:0]   starve_q;
  logic               grant_d, grant_i, done;
  logic               access_we_q;   // current/just-finished access is a store
  logic [DATA_W-1:0]  if_rdata_q, dm_rdata_q;

  // Next-state logic and arbitration decision.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_req && (!if_req || starve_q < STV_W'(STARVE_MAX))) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (if_req) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // counter reaches 0 on this edge: hand back to IDLE with ready high,
        // so the next grant can already be decided in the ready cycle
        if (lat_q == LAT_W'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Memory strobe, latched access fields, latency counter and ready pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_byte    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      access_we_q <= 1'b0;
      lat_q       <= '0;
      if_ready    <= 1'b0;
      dm_ready    <= 1'b0;
    end else begin
      mem_en   <= grant_d | grant_i;
      mem_we   <= grant_d & dm_we;
      if_ready <= done && (state_q == BUSY_I);
      dm_ready <= done && (state_q == BUSY_D);
      if (grant_d) begin
        mem_addr    <= dm_addr;
        mem_wdata   <= dm_wdata;
        mem_byte    <= dm_byte;
        access_we_q <= dm_we;
        lat_q       <= LAT_W'(MEM_LAT);
      end else if (grant_i) begin
        mem_addr    <= if_addr;
        mem_byte    <= 1'b0;
        access_we_q <= 1'b0;
        lat_q       <= LAT_W'(MEM_LAT);
      end else if (lat_q != '0) begin
        lat_q <= lat_q - LAT_W'(1);
      end
    end
  end

  // Starvation counter: consecutive data grants made over a waiting fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (grant_i || (state_q == IDLE && !if_req)) begin
      starve_q <= '0;
    end else if (grant_d && if_req && starve_q < STV_W'(STARVE_MAX)) begin
      starve_q <= starve_q + STV_W'(1);
    end
  end

  // Read-data hold registers: capture memory data at the end of the ready cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_ready)                 if_rdata_q <= mem_rdata;
      if (dm_ready && !access_we_q) dm_rdata_q <= mem_rdata;
    end
  end

  // During the ready cycle the memory data is passed straight through so the
  // requester sees it together with the pulse; afterwards the held copy.
  assign if_rdata  = if_ready                   ? mem_rdata : if_rdata_q;
  assign dm_rdata  = (dm_ready && !access_we_q) ? mem_rdata : dm_rdata_q;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

endmodule
